// File: rtl/mem_arbiter_if.sv
// Bundle of signals between the two requesters, the arbiter and the memory system.
interface mem_arbiter_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic [AW-1:0] p0_addr;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p0_wdata;
  logic [DW-1:0] p1_wdata;
  logic          p0_rd;
  logic          p1_rd;
  logic          p0_wr;
  logic          p1_wr;
  logic [DW-1:0] p0_rdata;
  logic [DW-1:0] p1_rdata;
  logic          p0_done;
  logic          p1_done;
  logic          p0_stall;
  logic          p1_stall;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;
  logic          mem_stall;
  logic          busy;
  logic          grant;

  modport slave (
    input  p0_addr, p1_addr, p0_wdata, p1_wdata, p0_rd, p1_rd, p0_wr, p1_wr,
    input  mem_rdata, mem_done, mem_stall,
    output p0_rdata, p1_rdata, p0_done, p1_done, p0_stall, p1_stall,
    output mem_addr, mem_wdata, mem_rd, mem_wr, busy, grant
  );

  modport master (
    output p0_addr, p1_addr, p0_wdata, p1_wdata, p0_rd, p1_rd, p0_wr, p1_wr,
    output mem_rdata, mem_done, mem_stall,
    input  p0_rdata, p1_rdata, p0_done, p1_done, p0_stall, p1_stall,
    input  mem_addr, mem_wdata, mem_rd, mem_wr, busy, grant
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-outstanding memory interface.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention; default is port 1 priority.
module mem_arbiter (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          rd_q;
  logic          wr_q;
  logic          done0_q;
  logic          done1_q;
  logic          busy_q;
  logic          grant_q;
  logic          req0;
  logic          req1;
  logic          win;
  logic          win_wr;
  logic          unused_mem_stall;

  assign req0   = bus.p0_rd | bus.p0_wr;
  assign req1   = bus.p1_rd | bus.p1_wr;
  assign win_wr = win ? bus.p1_wr : bus.p0_wr;
  assign unused_mem_stall = bus.mem_stall;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant;

  // On contention the port that did not win last time goes next.
  always_comb begin
    win = req1;
    if (req0 && req1) win = ~last_grant;
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant <= 1'b1;
    else if (state == IDLE && (req0 || req1)) last_grant <= win;
  end
`else
  always_comb begin
    win = req1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
      grant_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state   <= ISSUE;
            busy_q  <= 1'b1;
            grant_q <= win;
            addr_q  <= win ? bus.p1_addr : bus.p0_addr;
            wdata_q <= win ? bus.p1_wdata : bus.p0_wdata;
            wr_q    <= win_wr;
            rd_q    <= ~win_wr;
          end
        end
        ISSUE: begin
          // Strobes and payload are held until the memory completes.
          if (bus.mem_done) begin
            state   <= RESP;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            if (rd_q) rdata_q <= bus.mem_rdata;
            done0_q <= ~grant_q;
            done1_q <= grant_q;
          end
        end
        RESP: begin
          state   <= IDLE;
          busy_q  <= 1'b0;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.p0_rdata  = rdata_q;
  assign bus.p1_rdata  = rdata_q;
  assign bus.p0_done   = done0_q;
  assign bus.p1_done   = done1_q;
  assign bus.p0_stall  = req0 & ~done0_q;
  assign bus.p1_stall  = req1 & ~done1_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_rd    = rd_q;
  assign bus.mem_wr    = wr_q;
  assign bus.busy      = busy_q;
  assign bus.grant     = grant_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model checked every cycle.
module tb_mem_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder and requester controls
  int          wait_n;
  int          wcnt;
  logic [31:0] mem_val;
  bit          hold0;
  bit          hold1;
  int          glog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.mem_rd || bus.mem_wr) begin
      bus.mem_done = (wcnt == wait_n);
      wcnt++;
    end else begin
      bus.mem_done = 1'b0;
      wcnt = 0;
    end
    bus.mem_stall = (bus.mem_rd | bus.mem_wr) & ~bus.mem_done;
    bus.mem_rdata = mem_val;
    if (bus.p0_done && !hold0) begin bus.p0_rd = 1'b0; bus.p0_wr = 1'b0; end
    if (bus.p1_done && !hold1) begin bus.p1_rd = 1'b0; bus.p1_wr = 1'b0; end
  endtask

  // Reference model: one pending transaction record, a response slot and a gap cycle.
  bit          m_on;
  bit          m_txn;
  bit          m_resp;
  bit          m_port;
  bit          m_wr;
  bit          m_last;
  bit          m_grant;
  bit          m_d0;
  bit          m_d1;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  always @(posedge clk) begin
    bit r0, r1, p;
    if (rst) begin
      m_on = 1; m_txn = 0; m_resp = 0; m_d0 = 0; m_d1 = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_grant = 0; m_last = 1; m_wr = 0; m_port = 0;
    end else if (m_on) begin
      m_d0 = 0;
      m_d1 = 0;
      if (m_resp) begin
        m_resp = 0;
      end else if (m_txn) begin
        if (bus.mem_done) begin
          m_txn  = 0;
          m_resp = 1;
          if (!m_wr) m_rdata = bus.mem_rdata;
          if (m_port) m_d1 = 1; else m_d0 = 1;
        end
      end else begin
        r0 = bus.p0_rd | bus.p0_wr;
        r1 = bus.p1_rd | bus.p1_wr;
        if (r0 || r1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          p = (r0 && r1) ? !m_last : r1;
`else
          p = r1;
`endif
          m_last  = p;
          m_grant = p;
          m_port  = p;
          m_txn   = 1;
          m_wr    = p ? bus.p1_wr : bus.p0_wr;
          m_addr  = p ? bus.p1_addr : bus.p0_addr;
          m_wdata = p ? bus.p1_wdata : bus.p0_wdata;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_on && !rst) begin
      chk("mem_rd",   32'(bus.mem_rd),   32'(m_txn & !m_wr));
      chk("mem_wr",   32'(bus.mem_wr),   32'(m_txn & m_wr));
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_wdata", bus.mem_wdata, m_wdata);
      chk("busy",     32'(bus.busy),     32'(m_txn | m_resp));
      chk("grant",    32'(bus.grant),    32'(m_grant));
      chk("p0_done",  32'(bus.p0_done),  32'(m_d0));
      chk("p1_done",  32'(bus.p1_done),  32'(m_d1));
      chk("p0_rdata", bus.p0_rdata, m_rdata);
      chk("p1_rdata", bus.p1_rdata, m_rdata);
      chk("p0_stall", 32'(bus.p0_stall), 32'((bus.p0_rd | bus.p0_wr) & !m_d0));
      chk("p1_stall", 32'(bus.p1_stall), 32'((bus.p1_rd | bus.p1_wr) & !m_d1));
    end
    if (bus.p0_done) glog.push_back(0);
    if (bus.p1_done) glog.push_back(1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    int p0_cnt;
    int exp_g[4];
    total = 0; bad = 0;
    wait_n = 0; wcnt = 0; mem_val = '0; hold0 = 0; hold1 = 0;
    rst = 1'b1;
    bus.p0_addr = '0; bus.p1_addr = '0; bus.p0_wdata = '0; bus.p1_wdata = '0;
    bus.p0_rd = 0; bus.p0_wr = 0; bus.p1_rd = 0; bus.p1_wr = 0;
    bus.mem_rdata = '0; bus.mem_done = 0; bus.mem_stall = 0;
    do_reset();
    chk("rst_rdata", bus.p0_rdata, 32'h0);

    // Zero-wait read on port 0
    mem_val = 32'hDEAD_BEEF;
    bus.p0_addr = 32'h0000_0010; bus.p0_rd = 1'b1;
    step();
    chk("t27_mem_rd", 32'(bus.mem_rd), 32'd1);
    chk("t27_addr", bus.mem_addr, 32'h0000_0010);
    step();
    chk("t27_p0_done", 32'(bus.p0_done), 32'd1);
    chk("t27_p0_rdata", bus.p0_rdata, 32'hDEAD_BEEF);
    chk("t27_p1_done", 32'(bus.p1_done), 32'd0);
    idle(3);

    // Port 1 write with three memory wait cycles
    wait_n = 3;
    bus.p1_addr = 32'h20; bus.p1_wdata = 32'h1234_5678; bus.p1_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t28_mem_wr", 32'(bus.mem_wr), 32'd1);
      chk("t28_addr", bus.mem_addr, 32'h20);
      chk("t28_wdata", bus.mem_wdata, 32'h1234_5678);
      chk("t28_stall", 32'(bus.p1_stall), 32'd1);
      chk("t28_done_early", 32'(bus.p1_done), 32'd0);
    end
    step();
    chk("t28_p1_done", 32'(bus.p1_done), 32'd1);
    chk("t28_rdata_kept", bus.p1_rdata, 32'hDEAD_BEEF);
    idle(3);

    // Read and write together on port 0 behave as a write
    wait_n = 0; mem_val = 32'h5555_0000;
    bus.p0_addr = 32'h40; bus.p0_wdata = 32'hA5A5_A5A5; bus.p0_rd = 1'b1; bus.p0_wr = 1'b1;
    step();
    chk("t31_mem_wr", 32'(bus.mem_wr), 32'd1);
    chk("t31_mem_rd", 32'(bus.mem_rd), 32'd0);
    step();
    chk("t31_p0_done", 32'(bus.p0_done), 32'd1);
    chk("t31_rdata", bus.p0_rdata, 32'hDEAD_BEEF);
    idle(3);

    // Reset in the middle of an issued read
    wait_n = 5; mem_val = 32'h0BAD_F00D;
    bus.p0_addr = 32'h80; bus.p0_rd = 1'b1;
    step();
    chk("t30_mem_rd", 32'(bus.mem_rd), 32'd1);
    step();
    rst = 1'b1;
    step();
    chk("t30_rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    chk("t30_rst_busy", 32'(bus.busy), 32'd0);
    chk("t30_rst_done", 32'(bus.p0_done), 32'd0);
    rst = 1'b0; wait_n = 0;
    step();
    chk("t30_rearb", 32'(bus.mem_rd), 32'd1);
    chk("t30_rearb_addr", bus.mem_addr, 32'h80);
    step();
    chk("t30_done", 32'(bus.p0_done), 32'd1);
    chk("t30_rdata", bus.p0_rdata, 32'h0BAD_F00D);
    idle(3);

    // Continuous contention between both ports
    do_reset();
    glog.delete();
    hold0 = 1; hold1 = 1;
    mem_val = 32'h7777_0001;
    bus.p0_addr = 32'h100; bus.p1_addr = 32'h200;
    bus.p0_rd = 1'b1; bus.p1_rd = 1'b1;
    idle(14);
    bus.p0_rd = 1'b0; bus.p1_rd = 1'b0;
    hold0 = 0; hold1 = 0;
    idle(4);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{1, 1, 1, 1};
`endif
    chk("t29_count", 32'(glog.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t29_grant%0d", i), 32'(i < glog.size() ? glog[i] : 9), 32'(exp_g[i]));
    p0_cnt = 0;
    foreach (glog[i]) if (glog[i] == 0) p0_cnt++;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("t29_p0_served", 32'(p0_cnt >= 2), 32'd1);
`else
    chk("t29_p0_starved", 32'(p0_cnt), 32'd0);
`endif

    for (int i = 0; i < 20 && bus.busy; i++) step();
    chk("drain_idle", 32'(bus.busy), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
